pc_fetch_unit: RTL
==================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter TIMEOUT, default 16, maximum cycles a fetch may wait for imem_ready (range 1..255).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  fetch address, equal to pc while imem_req=1.
REQ-007 imem_ready  input  1  instruction memory returns data this cycle; sampled only while imem_req=1.
REQ-008 imem_rdata  input  32  instruction word, valid when imem_ready=1.
REQ-009 instr  output  32  registered instruction; decode drives instr[31:7] to the immediate generator.
REQ-010 instr_valid  output  1  instr and pc hold a fetched, unconsumed instruction.
REQ-011 instr_ack  input  1  downstream consumes the instruction; ignored unless instr_valid=1.
REQ-012 pc  output  32  address of the current instruction.
REQ-013 pc_plus4  output  32  pc + 4, modulo 2^32, for link writeback.
REQ-014 branch_taken  input  1  conditional branch resolved taken; sampled with instr_ack.
REQ-015 jump  input  1  JAL; sampled with instr_ack.
REQ-016 jalr  input  1  JALR; sampled with instr_ack.
REQ-017 imm_ext  input  32  sign-extended immediate from the immediate generator.
REQ-018 rs1_data  input  32  register operand for JALR target.
REQ-019 fault  output  1  sticky error flag.
REQ-020 fault_cause  output  2  00 none, 01 misaligned target, 10 fetch timeout.
REQ-021 instret  output  32  count of consumed instructions.

Function
REQ-022 FSM states: FETCH, HOLD, HALT.
REQ-023 FETCH: imem_req=1, imem_addr=pc, instr_valid=0; wait counter increments each cycle.
REQ-024 FETCH with imem_ready=1: instr <= imem_rdata, wait counter <= 0, next state HOLD; instr_valid=1 from the following cycle (one-cycle fetch latency minimum).
REQ-025 FETCH with imem_ready=0 when the wait counter equals TIMEOUT-1: fault=1, fault_cause=10, next state HALT.
REQ-026 HOLD: imem_req=0, instr_valid=1; instr and pc stable until acknowledged.
REQ-027 HOLD with instr_ack=1: compute next_pc, increment instret (wrapping 2^32-1 -> 0), next state FETCH, instr_valid=0 the next cycle.
REQ-028 next_pc priority: jalr -> (rs1_data + imm_ext) & ~32'h1; else jump or branch_taken -> pc + imm_ext; else pc + 4; all additions modulo 2^32.
REQ-029 If next_pc[1:0] != 00: pc not updated, instret still increments, fault=1, fault_cause=01, next state HALT.
REQ-030 HALT: imem_req=0, instr_valid=0, all registers frozen; exit only by reset.
REQ-031 Redirect inputs without instr_ack, or in FETCH/HALT, have no effect.
REQ-032 pc wrapping 32'hFFFF_FFFC + 4 -> 32'h0000_0000 is legal, no fault.
REQ-033 pc_plus4 combinational from pc.

Reset
REQ-034 rst_n=0 immediately forces: state FETCH, pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0, fault=0, fault_cause=00, instret=0, wait counter=0.
REQ-035 imem_req=1 in the first cycle after rst_n rises.
REQ-036 Reset asserted mid-fetch or in HOLD discards the pending instruction; no ack or instret update occurs.

Verification
REQ-037 Reset, imem_ready=1 next cycle with rdata 32'h0050_0093, ack -> instr_valid pulses, pc 0 -> 4, instret=1.
REQ-038 pc=0x100, ack with branch_taken=1, imm_ext=32'hFFFF_FFF0 -> next imem_addr=0x0F0; jump with imm_ext=0x20 from 0x0F0 -> 0x110.
REQ-039 jalr=1, rs1_data=0x203, imm_ext=0x0 -> target 0x202 -> fault=1, cause=01, pc unchanged, imem_req stays 0.
REQ-040 imem_ready held 0 for 16 cycles (TIMEOUT=16) -> fault=1, cause=10 at cycle 16; ready at cycle 15 -> no fault.
REQ-041 HOLD with instr_ack=0 for 5 cycles while branch_taken toggles -> instr, pc stable, no fetch issued.
REQ-042 rst_n pulsed low in HALT and mid-FETCH -> all outputs return to reset values asynchronously, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch bus between the fetch unit (master) and instruction memory (slave).
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch with redirect handling,
// bounded fetch wait, and a sticky fault that halts the unit until reset.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pc_fetch_unit_if.master        imem,
  output logic [31:0]            instr,
  output logic                   instr_valid,
  input  logic                   instr_ack,
  output logic [31:0]            pc,
  output logic [31:0]            pc_plus4,
  input  logic                   branch_taken,
  input  logic                   jump,
  input  logic                   jalr,
  input  logic [31:0]            imm_ext,
  input  logic [31:0]            rs1_data,
  output logic                   fault,
  output logic [1:0]             fault_cause,
  output logic [31:0]            instret
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instret_q, instret_d;
  logic        fault_q, fault_d;
  logic [1:0]  cause_q, cause_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] next_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      instret_q <= '0;
      fault_q   <= 1'b0;
      cause_q   <= 2'b00;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
      fault_q   <= fault_d;
      cause_q   <= cause_d;
      wait_q    <= wait_d;
    end
  end

  // JALR outranks JAL/branch; bit 0 of a JALR target is cleared before the alignment test.
  always_comb begin
    next_pc = pc_q + 32'd4;
    if (jalr) begin
      next_pc = (rs1_data + imm_ext) & ~32'h1;
    end else if (jump || branch_taken) begin
      next_pc = pc_q + imm_ext;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    fault_d   = fault_q;
    cause_d   = cause_q;
    wait_d    = wait_q;
    case (state_q)
      FETCH: begin
        if (imem.imem_ready) begin
          instr_d = imem.imem_rdata;
          wait_d  = '0;
          state_d = HOLD;
        end else if (wait_q == TIMEOUT_LAST) begin
          fault_d = 1'b1;
          cause_d = 2'b10;
          state_d = HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      HOLD: begin
        if (instr_ack) begin
          instret_d = instret_q + 32'd1;
          if (next_pc[1:0] != 2'b00) begin
            fault_d = 1'b1;
            cause_d = 2'b01;
            state_d = HALT;
          end else begin
            pc_d    = next_pc;
            state_d = FETCH;
          end
        end
      end
      HALT: begin
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  assign imem.imem_req  = (state_q == FETCH);
  assign imem.imem_addr = pc_q;
  assign instr_valid    = (state_q == HOLD);
  assign instr          = instr_q;
  assign pc             = pc_q;
  assign pc_plus4       = pc_q + 32'd4;
  assign fault          = fault_q;
  assign fault_cause    = cause_q;
  assign instret        = instret_q;

endmodule
